ysyx_23060075_ifu_axi_fetch: RTL and testbench
==============================================

Name: ysyx_23060075_ifu_axi_fetch

Overview:
Fetch-side memory bridge between the IFU core's simple instruction-read port and the AXI4-Lite read channel of the instruction memory or crossbar. It accepts one fetch request (pc) at a time, issues AR, waits for R, checks the response and alignment, then presents inst/pc/err to the IDU via valid/ready. It supports a flush (redirect) that discards an in-flight fetch without violating AXI.

Parameters:
ADDR_WIDTH, 32, width of the fetch address and araddr; equals `ysyx_23060075_ISA_WIDTH.
DATA_WIDTH, 32, width of rdata and inst.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  1  IFU requests a fetch.
req_addr  in  ADDR_WIDTH  fetch pc.
req_ready  out  1  bridge can accept a request.
flush  in  1  redirect: discard any pending or held fetch.
araddr  out  ADDR_WIDTH  AXI read address.
arvalid  out  1  AXI address valid.
arready  in  1  AXI address ready.
rdata  in  DATA_WIDTH  AXI read data.
rresp  in  2  AXI read response.
rvalid  in  1  AXI read valid.
rready  out  1  AXI read ready.
inst_valid  out  1  fetched instruction available to the IDU.
inst_ready  in  1  IDU accepts the instruction.
inst  out  DATA_WIDTH  instruction word; 0 when inst_err is 1.
inst_pc  out  ADDR_WIDTH  pc of the held instruction.
inst_err  out  1  access fault: rresp != OKAY, or req_addr[1:0] != 0.

Behaviour:
- Reset (async, rst=1): state IDLE, drop=0. arvalid, rready, inst_valid, inst_err, inst, inst_pc and araddr are 0. req_ready is 0 while rst=1.
- req_ready = (state==IDLE) & ~flush & ~rst. This is combinational; the other outputs are registered or decoded from state.
- FSM states: IDLE, AR, R, HOLD.
- IDLE: on req_valid & req_ready, latch req_addr into the addr/pc register.
  - If req_addr[1:0] != 0, go to HOLD with inst_err=1 and inst=0. No AXI traffic is issued.
  - Otherwise go to AR.
- AR: arvalid=1, araddr=latched addr. Both stay stable until arready. On arready, go to R.
- R: rready=1. On rvalid, capture rdata and rresp.
  - If drop=1, go to IDLE.
  - Otherwise inst=rdata and inst_err=(rresp!=2'b00), then go to HOLD. On error, inst=0.
- HOLD: inst_valid=1; inst, inst_pc and inst_err stay stable. On inst_ready, go to IDLE.
- Minimum latency (arready and rvalid zero-wait): request accepted at cycle T → arvalid T+1 → rready T+2 → inst_valid T+3. Throughput is one fetch in flight; req_ready is 1 again the cycle after the IDU handshake.
- Flush rules:
  - In IDLE: blocks acceptance that cycle.
  - In AR or R: set drop=1. AR is never withdrawn and the R beat is always consumed. The completion returns to IDLE with no inst_valid. drop clears on entry to IDLE.
  - In HOLD: inst_valid drops next cycle and the state goes to IDLE, even if inst_ready is high the same cycle; the IDU must also ignore on flush.
  - flush together with rvalid in R: the data is dropped.
- Repeated flush while drop=1 has no further effect.
- Reset mid-transaction: immediate return to IDLE. The AXI slave shares rst, so no orphan beats are expected.
- Ignored inputs: rvalid outside R and arready outside AR.

Decomposition:
- Shared header ysyx_23060075_isa.vh gains:
  - `ysyx_23060075_AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR (2-bit).
  - `ysyx_23060075_IFU_FETCH_STATE_WIDTH and the IDLE/AR/R/HOLD encodings.
- No sub-module is needed; the output hold register is plain flops in this module.

Test Plan:
- Zero-wait slave, req_addr=0x8000_0000, rdata=0x0000_0413, rresp=0 → arvalid at T+1, inst_valid at T+3 with inst=0x0000_0413, inst_pc=0x8000_0000, inst_err=0.
- arready delayed 3 cycles, rvalid delayed 2 → araddr/arvalid stable throughout; inst_valid at T+8; inst_ready held 0 for 4 cycles keeps inst stable.
- rresp=2'b10 (SLVERR) for addr 0x8000_0004 → inst_valid=1, inst_err=1, inst=0.
- req_addr=0x8000_0002 → no arvalid ever; inst_valid at T+1 with inst_err=1, inst_pc=0x8000_0002.
- flush one cycle in AR (arready late) → AR still completes, R beat consumed with rready=1, no inst_valid, req_ready=1 the cycle after rvalid. Next request at 0x8000_0100 fetches correctly.
- rst pulsed while in R → all outputs 0 immediately; after release, req_ready=1 and a new fetch completes normally.

Source files
------------

// File: rtl/ysyx_23060075_ifu_axi_fetch_pkg.sv
// ysyx_23060075_ifu_axi_fetch_pkg: shared AXI response codes and fetch FSM encoding
package ysyx_23060075_ifu_axi_fetch_pkg;
  localparam int ISA_WIDTH = 32;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam int IFU_FETCH_STATE_WIDTH = 2;
  typedef enum logic [IFU_FETCH_STATE_WIDTH-1:0] {
    FS_IDLE = 2'd0,
    FS_AR   = 2'd1,
    FS_R    = 2'd2,
    FS_HOLD = 2'd3
  } fetch_state_e;
  function automatic logic misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction
endpackage

// File: rtl/ysyx_23060075_ifu_axi_fetch.sv
// ysyx_23060075_ifu_axi_fetch: one-in-flight IFU fetch bridge onto an AXI4-Lite read channel
module ysyx_23060075_ifu_axi_fetch
  import ysyx_23060075_ifu_axi_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = ISA_WIDTH,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  inst_err
);
  fetch_state_e          state_q, state_d;
  logic                  drop_q, drop_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic                  err_q, err_d;
  logic                  resp_err;
  assign req_ready  = (state_q == FS_IDLE) & ~flush & ~rst;
  assign arvalid    = state_q == FS_AR;
  assign rready     = state_q == FS_R;
  assign inst_valid = state_q == FS_HOLD;
  assign araddr     = addr_q;
  assign inst_pc    = addr_q;
  assign inst       = inst_q;
  assign inst_err   = err_q;
  assign resp_err   = rresp != AXI_RESP_OKAY;
  // next state; a flush during AR/R only marks the beat to be discarded so AXI is never withdrawn
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    err_d   = err_q;
    case (state_q)
      FS_IDLE: if (req_valid && req_ready) begin
        addr_d  = req_addr;
        state_d = misaligned(req_addr[1:0]) ? FS_HOLD : FS_AR;
        if (misaligned(req_addr[1:0])) begin
          err_d  = 1'b1;
          inst_d = '0;
        end
      end
      FS_AR: begin
        drop_d  = drop_q | flush;
        state_d = arready ? FS_R : FS_AR;
      end
      FS_R: begin
        drop_d = drop_q | flush;
        if (rvalid) begin
          state_d = (drop_q | flush) ? FS_IDLE : FS_HOLD;
          err_d   = resp_err;
          inst_d  = resp_err ? '0 : rdata;
        end
      end
      default: state_d = (flush | inst_ready) ? FS_IDLE : FS_HOLD;
    endcase
    if (state_d == FS_IDLE) drop_d = 1'b0;
  end
  // state and held-instruction registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FS_IDLE;
      drop_q  <= 1'b0;
      addr_q  <= '0;
      inst_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_ysyx_23060075_ifu_axi_fetch.sv
// tb_ysyx_23060075_ifu_axi_fetch: directed latency/flush/reset scenarios plus random traffic against a fetch-level model
module tb_ysyx_23060075_ifu_axi_fetch;
  logic        clk = 0, rst = 1;
  logic        req_valid = 0, flush = 0, arready = 0, rvalid = 0, inst_ready = 0;
  logic [31:0] req_addr = 0, rdata = 0;
  logic [1:0]  rresp = 0;
  logic        req_ready, arvalid, rready, inst_valid, inst_err;
  logic [31:0] araddr, inst, inst_pc;
  int checks = 0, errors = 0;

  ysyx_23060075_ifu_axi_fetch dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .flush(flush), .araddr(araddr), .arvalid(arvalid), .arready(arready), .rdata(rdata),
    .rresp(rresp), .rvalid(rvalid), .rready(rready), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .inst_err(inst_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  // Fetch-level model: one outstanding fetch, tracked by which protocol phases have completed.
  logic        m_active = 0, m_addr_sent = 0, m_done = 0, m_discard = 0;
  logic [31:0] m_pc = 0, m_inst = 0;
  logic        m_err = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0; m_addr_sent = 0; m_done = 0; m_discard = 0;
    end else if (!m_active) begin
      if (req_valid && !flush) begin
        m_active = 1; m_pc = req_addr; m_discard = 0;
        m_err = req_addr[1:0] != 0;
        m_addr_sent = m_err; m_done = m_err; m_inst = 0;
      end
    end else if (m_done) begin
      if (flush || inst_ready) m_active = 0;
    end else begin
      if (flush) m_discard = 1;
      if (!m_addr_sent) begin
        if (arready) m_addr_sent = 1;
      end else if (rvalid) begin
        if (m_discard) m_active = 0;
        else begin
          m_done = 1; m_err = rresp != 0; m_inst = m_err ? 0 : rdata;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("req_ready", req_ready, !rst && !m_active && !flush);
    chk("arvalid", arvalid, m_active && !m_addr_sent);
    chk("rready", rready, m_active && m_addr_sent && !m_done);
    chk("inst_valid", inst_valid, m_active && m_done);
    if (m_active && !m_addr_sent) chk("araddr", araddr, m_pc);
    if (m_active && m_done) begin
      chk("inst", inst, m_inst);
      chk("inst_pc", inst_pc, m_pc);
      chk("inst_err", inst_err, m_err);
    end
    if (rst) chk("rst_zero", {araddr, inst, inst_pc, inst_err}, 0);
  end

  task automatic cyc(); @(posedge clk); #2; endtask
  task automatic at_neg(); @(negedge clk); #1; endtask

  initial begin
    cyc(); at_neg();
    chk("L_rst_ready", req_ready, 0);
    chk("L_rst_outs", {arvalid, rready, inst_valid, inst_err, araddr, inst, inst_pc}, 0);
    cyc(); rst = 0;
    // zero-wait fetch
    arready = 1; rvalid = 1; rdata = 32'h0000_0413; rresp = 0;
    cyc(); req_valid = 1; req_addr = 32'h8000_0000; at_neg();
    chk("L1_req_ready", req_ready, 1);
    cyc(); req_valid = 0; at_neg();
    chk("L1_arvalid", arvalid, 1);
    chk("L1_araddr", araddr, 32'h8000_0000);
    cyc(); at_neg();
    chk("L1_rready", rready, 1);
    chk("L1_iv_early", inst_valid, 0);
    cyc(); at_neg();
    chk("L1_iv", inst_valid, 1);
    chk("L1_inst", inst, 32'h0000_0413);
    chk("L1_pc", inst_pc, 32'h8000_0000);
    chk("L1_err", inst_err, 0);
    inst_ready = 1; cyc(); inst_ready = 0; at_neg();
    chk("L1_idle", {inst_valid, req_ready}, 2'b01);
    // delayed slave, IDU stall
    arready = 0; rvalid = 0; rdata = 32'hDEAD_BEEF;
    cyc(); req_valid = 1; req_addr = 32'h8000_0008;
    cyc(); req_valid = 0;
    for (int k = 1; k <= 8; k++) begin
      arready = k == 4; rvalid = k == 7; at_neg();
      chk("L2_arvalid", arvalid, k <= 4);
      if (k <= 4) chk("L2_araddr", araddr, 32'h8000_0008);
      chk("L2_iv", inst_valid, k == 8);
      if (k < 8) cyc();
    end
    arready = 0; rvalid = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(); at_neg();
      chk("L2_hold", {inst_valid, inst}, {1'b1, 32'hDEAD_BEEF});
    end
    inst_ready = 1; cyc(); inst_ready = 0;
    // SLVERR
    arready = 1; rvalid = 1; rresp = 2'b10; rdata = 32'h1234_5678;
    req_valid = 1; req_addr = 32'h8000_0004;
    cyc(); req_valid = 0; cyc(); cyc(); at_neg();
    chk("L3_err", {inst_valid, inst_err, inst}, {2'b11, 32'h0});
    inst_ready = 1; cyc(); inst_ready = 0; rresp = 0;
    // misaligned
    req_valid = 1; req_addr = 32'h8000_0002;
    cyc(); req_valid = 0; at_neg();
    chk("L4_mis", {arvalid, inst_valid, inst_err, inst}, {3'b011, 32'h0});
    chk("L4_pc", inst_pc, 32'h8000_0002);
    inst_ready = 1; cyc(); inst_ready = 0;
    // flush while in AR
    arready = 0; rvalid = 0; rdata = 32'h0BAD_0BAD;
    req_valid = 1; req_addr = 32'h8000_0010;
    cyc(); req_valid = 0; flush = 1;
    cyc(); flush = 0; arready = 1;
    cyc(); arready = 0; rvalid = 1; at_neg();
    chk("L5_rready", rready, 1);
    cyc(); rvalid = 0; at_neg();
    chk("L5_idle", {inst_valid, req_ready}, 2'b01);
    arready = 1; rvalid = 1; rdata = 32'h0010_0093;
    req_valid = 1; req_addr = 32'h8000_0100;
    cyc(); req_valid = 0; cyc(); cyc(); at_neg();
    chk("L5_next", {inst_valid, inst, inst_pc}, {1'b1, 32'h0010_0093, 32'h8000_0100});
    inst_ready = 1; cyc(); inst_ready = 0;
    // reset while in R
    rvalid = 0; req_valid = 1; req_addr = 32'h8000_0020;
    cyc(); req_valid = 0; cyc(); rst = 1; #1;
    chk("L6_rst", {arvalid, rready, inst_valid, req_ready, araddr}, 0);
    cyc(); rst = 0; at_neg();
    chk("L6_ready", req_ready, 1);
    rvalid = 1; rdata = 32'h0000_0013; req_valid = 1; req_addr = 32'h8000_0024;
    cyc(); req_valid = 0; cyc(); cyc(); at_neg();
    chk("L6_fetch", {inst_valid, inst, inst_pc}, {1'b1, 32'h0000_0013, 32'h8000_0024});
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc();
      rst        = $urandom_range(0, 199) == 0;
      req_valid  = $urandom_range(0, 3) != 0;
      req_addr   = {$urandom_range(0, 65535), 14'($urandom), ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00};
      flush      = $urandom_range(0, 9) == 0;
      arready    = $urandom_range(0, 1) == 1;
      rvalid     = $urandom_range(0, 2) == 0;
      rdata      = $urandom;
      rresp      = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      inst_ready = $urandom_range(0, 1) == 1;
    end
    cyc(); rst = 0; at_neg();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
